game_tick_timer: RTL

//  Consumer end of the 1 s game clock: samples the slow toggling game_clk level, converts each

---
 rtl/game_tick_timer_pkg.sv | 25 ++
 rtl/game_tick_timer_if.sv | 32 +++
 rtl/game_tick_timer_tick_edge_sync.sv | 30 +++
 rtl/game_tick_timer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/game_tick_timer_pkg.sv
// Shared types and constants for the game tick timer: FSM state encoding,
// default time limit, BCD digit width and the binary-to-two-digit-BCD helper.
package game_tick_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Two BCD digits on the display cap the loadable time at 99 s.
    localparam int DEFAULT_MAX_TIME = 99;
    localparam int BCD_W            = 4;

    // Split a value in 0..99 into {tens, ones} BCD digits.
    function automatic logic [2*BCD_W-1:0] to_bcd2(input int unsigned value);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = BCD_W'(value / 10);
        ones = BCD_W'(value % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/game_tick_timer_if.sv
// Signal bundle between the game FSM side (master) and the tick timer (slave).
interface game_tick_timer_if #(
    parameter int TW = 8
);
    import game_tick_timer_pkg::*;

    logic             game_clk;
    logic             start;
    logic             pause;
    logic [TW-1:0]    load_val;
    logic             tick;
    logic [TW-1:0]    time_left;
    logic [BCD_W-1:0] bcd_tens;
    logic [BCD_W-1:0] bcd_ones;
    logic             running;
    logic             game_over;
    logic             timeout;
    logic             tick_lost;

    modport master (
        output game_clk, start, pause, load_val,
        input  tick, time_left, bcd_tens, bcd_ones,
               running, game_over, timeout, tick_lost
    );

    modport slave (
        input  game_clk, start, pause, load_val,
        output tick, time_left, bcd_tens, bcd_ones,
               running, game_over, timeout, tick_lost
    );

endinterface

// File: rtl/game_tick_timer_tick_edge_sync.sv
// Brings the slow game_clk level into the clk domain and turns every toggle
// (rising or falling) into a registered one-cycle tick pulse.
module tick_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic game_clk,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain, last synchronized level, and registered toggle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Chain seeds 0, so a level already high at release shows up as one toggle.
            sync_q <= '0;
            prev_q <= 1'b0;
            tick   <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage takes its neighbour's old value; blocking would collapse the chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], game_clk};
            prev_q <= sync_q[SYNC_STAGES-1];
            tick   <= sync_q[SYNC_STAGES-1] ^ prev_q;
        end
    end

endmodule

// File: rtl/game_tick_timer.sv
// Round countdown timer driven by the 1 s game clock.
// Optional tick watchdog enabled by defining GAME_TICK_WATCHDOG_EN; without it
// tick_lost is tied low and no counter exists.
module game_tick_timer
    import game_tick_timer_pkg::*;
#(
    parameter int TW          = 8,
    parameter int MAX_TIME    = DEFAULT_MAX_TIME,
    parameter int SYNC_STAGES = 2,
    parameter int WDT_CYCLES  = 150000000
) (
    input  logic              clk,
    input  logic              rst_n,
    game_tick_timer_if.slave  bus
);

    localparam logic [TW-1:0] MAX_TL = TW'(MAX_TIME);

    state_t           state;
    logic             tick;
    logic [TW-1:0]    load_sat;
    logic [TW-1:0]    time_left_q;
    logic             running_q;
    logic             game_over_q;
    logic             timeout_q;
    logic [2*BCD_W-1:0] bcd;

    tick_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .game_clk (bus.game_clk),
        .tick     (tick)
    );

    // Loaded time saturates so the two-digit display never overflows.
    assign load_sat = (bus.load_val > MAX_TL) ? MAX_TL : bus.load_val;

    // Countdown FSM; priority start > pause > tick, all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            time_left_q <= '0;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (bus.start) begin
                time_left_q <= load_sat;
                if (load_sat == '0) begin
                    state       <= DONE;
                    running_q   <= 1'b0;
                    game_over_q <= 1'b1;
                    timeout_q   <= 1'b1;
                end else begin
                    state       <= RUN;
                    running_q   <= 1'b1;
                    game_over_q <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        time_left_q <= '0;
                    end
                    RUN: begin
                        if (bus.pause) begin
                            state     <= PAUSE;
                            running_q <= 1'b0;
                        end else if (tick) begin
                            if (time_left_q > TW'(1)) begin
                                time_left_q <= time_left_q - TW'(1);
                            end else begin
                                // Last second expired (also guards against wrapping below 0).
                                time_left_q <= '0;
                                state       <= DONE;
                                running_q   <= 1'b0;
                                game_over_q <= 1'b1;
                                timeout_q   <= 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        // Ticks during pause are dropped; the partial second is lost.
                        if (!bus.pause) begin
                            state     <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        time_left_q <= '0;
                    end
                    default: begin
                        state       <= IDLE;
                        running_q   <= 1'b0;
                        game_over_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Display digits follow time_left combinationally; time_left never exceeds 99.
    assign bcd = to_bcd2(32'(time_left_q));

    assign bus.tick      = tick;
    assign bus.time_left = time_left_q;
    assign bus.bcd_tens  = bcd[2*BCD_W-1:BCD_W];
    assign bus.bcd_ones  = bcd[BCD_W-1:0];
    assign bus.running   = running_q;
    assign bus.game_over = game_over_q;
    assign bus.timeout   = timeout_q;

`ifdef GAME_TICK_WATCHDOG_EN
    localparam int               WDT_W     = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(WDT_CYCLES);

    logic [WDT_W-1:0] wdt_cnt;
    logic             tick_lost_q;

    // Cycles in RUN since the last tick; saturates and raises a sticky flag at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt     <= '0;
            tick_lost_q <= 1'b0;
        end else if (bus.start) begin
            wdt_cnt     <= '0;
            tick_lost_q <= 1'b0;
        end else if (tick) begin
            wdt_cnt <= '0;
        end else if (state == RUN && wdt_cnt != WDT_LIMIT) begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
            if (wdt_cnt == WDT_LIMIT - WDT_W'(1)) begin
                tick_lost_q <= 1'b1;
            end
        end
    end

    assign bus.tick_lost = tick_lost_q;
`else
    assign bus.tick_lost = 1'b0;
`endif

endmodule
